// File: rtl/arp_cache_table.sv
// Multi-entry IP-to-MAC cache: learn with refresh/oldest-replacement, tick aging,
// flush, and a three-state lookup pipeline that triggers an ARP request on miss.
module arp_cache_table #(
  parameter int ENTRIES = 4,
  parameter int TTL     = 300,
  parameter int AGE_W   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           learn_valid,
  input  logic [31:0]                    learn_ip,
  input  logic [47:0]                    learn_mac,
  input  logic                           lookup_valid,
  input  logic [31:0]                    lookup_ip,
  output logic                           lookup_ready,
  output logic                           lookup_done,
  output logic                           lookup_hit,
  output logic [47:0]                    lookup_mac,
  output logic                           arp_rq_start,
  output logic [31:0]                    arp_rq_ip,
  input  logic                           tick,
  input  logic                           flush,
  output logic [$clog2(ENTRIES+1)-1:0]   entry_count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [ENTRIES-1:0] r_valid;
  logic [31:0]        r_ip  [ENTRIES];
  logic [47:0]        r_mac [ENTRIES];
  logic [AGE_W-1:0]   r_age [ENTRIES];
  logic [CW-1:0]      r_count;

  logic [31:0]        r_cap_ip;
  logic               r_done;
  logic               r_hit;
  logic [47:0]        r_mac_out;
  logic               r_arp_start;
  logic [31:0]        r_arp_ip;

  logic [ENTRIES-1:0] w_learn_match;
  logic [ENTRIES-1:0] w_cmp_match;
  logic [ENTRIES-1:0] w_wr;
  logic [ENTRIES-1:0] w_valid_next;
  logic [AGE_W-1:0]   w_age_next [ENTRIES];
  logic [IW-1:0]      w_match_idx;
  logic [IW-1:0]      w_free_idx;
  logic [IW-1:0]      w_min_idx;
  logic [AGE_W-1:0]   w_min_age;
  logic [IW-1:0]      w_tgt;
  logic [CW-1:0]      w_count_next;
  logic [47:0]        w_cmp_mac;
  logic               w_bypass;
  logic               w_cmp_hit;
  logic [47:0]        w_cmp_mac_sel;

  // Per-entry match and next-state; flush dominates learn, learn dominates aging.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign w_learn_match[gi] = r_valid[gi] && (r_ip[gi] == learn_ip);
      assign w_cmp_match[gi]   = r_valid[gi] && (r_ip[gi] == r_cap_ip);
      assign w_wr[gi]          = learn_valid && !flush && (w_tgt == IW'(gi));
      assign w_valid_next[gi]  = flush ? 1'b0 :
                                 w_wr[gi] ? 1'b1 :
                                 (tick && r_valid[gi] && r_age[gi] <= AGE_W'(1)) ? 1'b0 :
                                 r_valid[gi];
      assign w_age_next[gi]    = flush ? '0 :
                                 w_wr[gi] ? AGE_W'(TTL) :
                                 (tick && r_valid[gi]) ?
                                   ((r_age[gi] <= AGE_W'(1)) ? '0 : r_age[gi] - AGE_W'(1)) :
                                 r_age[gi];
    end
  endgenerate

  // Learn target: existing binding, else lowest free slot, else oldest (lowest index on ties).
  always_comb begin
    w_match_idx = '0;
    w_free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_learn_match[i]) w_match_idx = IW'(i);
      if (!r_valid[i])      w_free_idx  = IW'(i);
    end
    w_min_idx = '0;
    w_min_age = r_age[0];
    for (int i = 1; i < ENTRIES; i++) begin
      if (r_age[i] < w_min_age) begin
        w_min_idx = IW'(i);
        w_min_age = r_age[i];
      end
    end
    if (|w_learn_match)  w_tgt = w_match_idx;
    else if (~&r_valid)  w_tgt = w_free_idx;
    else                 w_tgt = w_min_idx;
  end

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_count_next = w_count_next + CW'(w_valid_next[i]);
    end
  end

  // Learned IPs are unique in the table, so OR-combining matched MACs is safe.
  always_comb begin
    w_cmp_mac = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_cmp_match[i]) w_cmp_mac = w_cmp_mac | r_mac[i];
    end
  end

  assign w_bypass      = learn_valid && (learn_ip == r_cap_ip);
  assign w_cmp_hit     = !flush && (w_bypass || (|w_cmp_match));
  assign w_cmp_mac_sel = flush ? '0 : (w_bypass ? learn_mac : w_cmp_mac);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ip[i]  <= '0;
        r_mac[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
      for (int i = 0; i < ENTRIES; i++) begin
        r_age[i] <= w_age_next[i];
        if (w_wr[i]) begin
          r_ip[i]  <= learn_ip;
          r_mac[i] <= learn_mac;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (lookup_valid) w_state_next = S_COMPARE;
      S_COMPARE: w_state_next = S_RESP;
      S_RESP:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Result registers load on the COMPARE->RESP edge so they are visible during RESP.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cap_ip    <= '0;
      r_done      <= 1'b0;
      r_hit       <= 1'b0;
      r_mac_out   <= '0;
      r_arp_start <= 1'b0;
      r_arp_ip    <= '0;
    end else begin
      r_done      <= (r_state == S_COMPARE);
      r_arp_start <= (r_state == S_COMPARE) && !w_cmp_hit;
      if (r_state == S_IDLE && lookup_valid) r_cap_ip <= lookup_ip;
      if (r_state == S_COMPARE) begin
        r_hit     <= w_cmp_hit;
        r_mac_out <= w_cmp_mac_sel;
        if (!w_cmp_hit) r_arp_ip <= r_cap_ip;
      end
    end
  end

  assign lookup_ready = (r_state == S_IDLE);
  assign lookup_done  = r_done;
  assign lookup_hit   = r_hit;
  assign lookup_mac   = r_mac_out;
  assign arp_rq_start = r_arp_start;
  assign arp_rq_ip    = r_arp_ip;
  assign entry_count  = r_count;

endmodule

// File: tb/tb_arp_cache_table.sv
// Directed plus randomized bench for arp_cache_table against a behavioural cache model.
module tb_arp_cache_table;
  localparam int ENTRIES = 4;
  localparam int TTL     = 5;
  localparam int AGE_W   = 16;
  localparam int CW      = $clog2(ENTRIES + 1);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          learn_valid = 1'b0;
  logic [31:0]   learn_ip = '0;
  logic [47:0]   learn_mac = '0;
  logic          lookup_valid = 1'b0;
  logic [31:0]   lookup_ip = '0;
  logic          lookup_ready;
  logic          lookup_done;
  logic          lookup_hit;
  logic [47:0]   lookup_mac;
  logic          arp_rq_start;
  logic [31:0]   arp_rq_ip;
  logic          tick = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] entry_count;

  always #5 aclk = ~aclk;

  arp_cache_table #(.ENTRIES(ENTRIES), .TTL(TTL), .AGE_W(AGE_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .learn_valid(learn_valid), .learn_ip(learn_ip), .learn_mac(learn_mac),
    .lookup_valid(lookup_valid), .lookup_ip(lookup_ip), .lookup_ready(lookup_ready),
    .lookup_done(lookup_done), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
    .arp_rq_start(arp_rq_start), .arp_rq_ip(arp_rq_ip),
    .tick(tick), .flush(flush), .entry_count(entry_count)
  );

  int checks = 0;
  int errors = 0;

  bit          m_valid [ENTRIES];
  logic [31:0] m_ip    [ENTRIES];
  logic [47:0] m_mac   [ENTRIES];
  int          m_age   [ENTRIES];
  logic        e_hit = 1'b0;
  logic [47:0] e_mac = '0;
  logic [31:0] e_arp_ip = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_ip[i] = '0; m_mac[i] = '0; m_age[i] = 0;
    end
  endtask

  // Table contents after the coming edge, given the inputs currently driven.
  task automatic model_edge();
    int t;
    t = -1;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else begin
      if (learn_valid) begin
        for (int i = 0; i < ENTRIES; i++)
          if (t < 0 && m_valid[i] && m_ip[i] == learn_ip) t = i;
        for (int i = 0; i < ENTRIES; i++)
          if (t < 0 && !m_valid[i]) t = i;
        if (t < 0) begin
          t = 0;
          for (int i = 1; i < ENTRIES; i++) if (m_age[i] < m_age[t]) t = i;
        end
      end
      if (tick)
        for (int i = 0; i < ENTRIES; i++)
          if (m_valid[i] && i != t) begin
            if (m_age[i] == 1) m_valid[i] = 1'b0;
            else m_age[i] = m_age[i] - 1;
          end
      if (t >= 0) begin
        m_valid[t] = 1'b1; m_ip[t] = learn_ip; m_mac[t] = learn_mac; m_age[t] = TTL;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge aclk);
    #1;
    chk("entry_count", entry_count, m_count());
  endtask

  task automatic do_learn(input logic [31:0] ip, input logic [47:0] mac, input bit with_tick);
    learn_valid = 1'b1; learn_ip = ip; learn_mac = mac; tick = with_tick;
    step();
    learn_valid = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] ip, input bit c_learn, input logic [31:0] c_ip,
                           input logic [47:0] c_mac, input bit c_tick, input bit c_flush);
    lookup_valid = 1'b1; lookup_ip = ip;
    chk("ready_idle", lookup_ready, 1'b1);
    step();
    lookup_valid = 1'b0; lookup_ip = $urandom;
    chk("done_early", lookup_done, 1'b0);
    chk("ready_cmp", lookup_ready, 1'b0);
    learn_valid = c_learn; learn_ip = c_ip; learn_mac = c_mac; tick = c_tick; flush = c_flush;
    if (c_flush) begin
      e_hit = 1'b0; e_mac = '0;
    end else if (c_learn && c_ip == ip) begin
      e_hit = 1'b1; e_mac = c_mac;
    end else begin
      e_hit = 1'b0; e_mac = '0;
      for (int i = 0; i < ENTRIES; i++)
        if (m_valid[i] && m_ip[i] == ip) begin e_hit = 1'b1; e_mac = m_mac[i]; end
    end
    if (!e_hit) e_arp_ip = ip;
    step();
    learn_valid = 1'b0; tick = 1'b0; flush = 1'b0;
    $display("lookup ip=%08h hit=%0d mac=%012h arp_rq=%0d", ip, lookup_hit, lookup_mac, arp_rq_start);
    chk("done", lookup_done, 1'b1);
    chk("hit", lookup_hit, e_hit);
    chk("mac", lookup_mac, e_mac);
    chk("arp_start", arp_rq_start, !e_hit);
    chk("arp_ip", arp_rq_ip, e_arp_ip);
    chk("ready_resp", lookup_ready, 1'b0);
    step();
    chk("done_pulse", lookup_done, 1'b0);
    chk("arp_pulse", arp_rq_start, 1'b0);
    chk("ready_back", lookup_ready, 1'b1);
    chk("hit_hold", lookup_hit, e_hit);
    chk("mac_hold", lookup_mac, e_mac);
  endtask

  initial begin
    logic [31:0] rip;
    model_clear();
    @(posedge aclk); #1;
    chk("rst_ready", lookup_ready, 1'b1);
    chk("rst_done", lookup_done, 1'b0);
    chk("rst_hit", lookup_hit, 1'b0);
    chk("rst_mac", lookup_mac, 48'h0);
    chk("rst_arp", arp_rq_start, 1'b0);
    chk("rst_arp_ip", arp_rq_ip, 32'h0);
    chk("rst_count", entry_count, 0);
    aresetn = 1'b1;
    step();

    // Miss on empty table, then a learned hit.
    do_lookup(32'hC0A80163, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("arp_ip_99", arp_rq_ip, 32'hC0A80163);
    do_learn(32'hC0A8010A, 48'h001122334455, 1'b0);
    chk("count_one", entry_count, 1);
    do_lookup(32'hC0A8010A, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("mac_10", lookup_mac, 48'h001122334455);

    // Oldest-entry replacement.
    do_flush();
    for (int k = 1; k <= 4; k++) do_learn(32'hC0A80100 + k, 48'hA00000000000 + k, 1'b0);
    for (int k = 0; k < 3; k++) do_tick();
    do_learn(32'hC0A80101, 48'hB00000000001, 1'b0);
    do_learn(32'hC0A80103, 48'hB00000000003, 1'b0);
    do_learn(32'hC0A80104, 48'hB00000000004, 1'b0);
    do_learn(32'hC0A80105, 48'hB00000000005, 1'b0);
    chk("count_full", entry_count, 4);
    do_lookup(32'hC0A80102, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("replaced_miss", lookup_hit, 1'b0);
    do_lookup(32'hC0A80105, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("new_hit_mac", lookup_mac, 48'hB00000000005);
    chk("count_stays", entry_count, 4);

    // Expiry after TTL ticks.
    do_flush();
    do_learn(32'hC0A80107, 48'h070707070707, 1'b0);
    for (int k = 0; k < TTL - 1; k++) do_tick();
    chk("pre_expire", entry_count, 1);
    do_tick();
    chk("expired", entry_count, 0);
    do_lookup(32'hC0A80107, 1'b0, '0, '0, 1'b0, 1'b0);

    // Learn beats a same-cycle tick on the same entry.
    do_learn(32'hC0A80107, 48'h070707070707, 1'b0);
    do_tick();
    do_learn(32'hC0A80107, 48'h171717171717, 1'b1);
    for (int k = 0; k < TTL - 1; k++) do_tick();
    chk("refresh_alive", entry_count, 1);
    do_lookup(32'hC0A80107, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("refresh_mac", lookup_mac, 48'h171717171717);

    // Learn bypass and flush during COMPARE.
    do_lookup(32'hC0A80108, 1'b1, 32'hC0A80108, 48'hDEADBEEF0008, 1'b0, 1'b0);
    chk("bypass_hit", lookup_hit, 1'b1);
    do_lookup(32'hC0A80107, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("flush_miss", lookup_hit, 1'b0);
    chk("flush_count", entry_count, 0);

    // Randomized traffic over a small IP pool to exercise replacement.
    for (int n = 0; n < 200; n++) begin
      rip = 32'hC0A80200 + $urandom_range(1, 7);
      if ($urandom_range(0, 3) == 0) begin
        do_lookup(rip, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 1) == 0) ? rip : 32'hC0A80200 + $urandom_range(1, 7),
                  {16'($urandom), $urandom}, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0));
      end else begin
        learn_valid = ($urandom_range(0, 1) == 0);
        learn_ip    = 32'hC0A80200 + $urandom_range(1, 7);
        learn_mac   = {16'($urandom), $urandom};
        tick        = ($urandom_range(0, 2) == 0);
        flush       = ($urandom_range(0, 40) == 0);
        step();
        learn_valid = 1'b0; tick = 1'b0; flush = 1'b0;
      end
    end

    // Asynchronous reset while a lookup sits in COMPARE.
    do_learn(32'hC0A8010A, 48'h001122334455, 1'b0);
    do_lookup(32'hC0A80163, 1'b0, '0, '0, 1'b0, 1'b0);
    do_lookup(32'hC0A8010A, 1'b0, '0, '0, 1'b0, 1'b0);
    lookup_valid = 1'b1; lookup_ip = 32'hC0A8010A;
    step();
    lookup_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    model_clear();
    e_hit = 1'b0; e_mac = '0; e_arp_ip = '0;
    chk("arst_ready", lookup_ready, 1'b1);
    chk("arst_done", lookup_done, 1'b0);
    chk("arst_hit", lookup_hit, 1'b0);
    chk("arst_mac", lookup_mac, 48'h0);
    chk("arst_arp", arp_rq_start, 1'b0);
    chk("arst_arp_ip", arp_rq_ip, 32'h0);
    chk("arst_count", entry_count, 0);
    step();
    aresetn = 1'b1;
    step();
    chk("post_rst_resp", lookup_done, 1'b0);
    do_lookup(32'hC0A8010A, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("post_rst_miss", lookup_hit, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
